// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so WIDTH+1 bits suffice and the MSB is the borrow.
  assign shifted  = {rem, quo_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign quo_bit  = ~diff[WIDTH];
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit with a start/busy/done handshake.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [1:0]         op_q, op_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;
  logic               is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   quo_fin, rem_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo_msb  (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_bit  (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    is_signed = ~op[0];
    a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
    quo_fin   = {quo_q[WIDTH-2:0], step_bit};
    rem_fin   = step_rem;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d      = op;
          quo_d     = a_abs;
          dvs_d     = b_abs;
          rem_d     = '0;
          neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = is_signed & a[WIDTH-1];
          // Division by zero bypasses CALC: all-ones quotient, raw dividend remainder.
          if (b == '0) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = op[1] ? a : '1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = quo_fin;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (op_q[1]) result_d = neg_rem_q ? -rem_fin : rem_fin;
          else         result_d = neg_quo_q ? -quo_fin : quo_fin;
        end
      end
      default: state_d = IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider with hand-computed expectations.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int bcnt;
  int dcnt;

  iter_divider #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request just after an edge and counts edges until done is seen.
  // inj > 0 pulses a different start request at that edge count.
  task automatic run(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input int inj, output int l, output int bc);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    l     = 0;
    bc    = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      l++;
      if (busy) bc++;
      if (l == inj) begin
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd50;
        b     = 32'd5;
      end
      if (done) break;
    end
    $display("op=%b a=%h b=%h -> result=%h zero=%0b latency=%0d busy_cycles=%0d",
             o, av, bv, result, zero, l, bc);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run(2'b01, 32'd20, 32'd3, 0, lat, bcnt);
    chk("divu_20_3", result, 32'd6);
    chk("divu_latency", lat, 33);
    chk("divu_busy_cycles", bcnt, 32);
    chk("divu_zero", {31'd0, zero}, 32'd0);

    // Back-to-back: start issued during the DONE cycle.
    run(2'b11, 32'd20, 32'd3, 0, lat, bcnt);
    chk("remu_20_3", result, 32'd2);
    chk("b2b_latency", lat, 33);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_held", result, 32'd2);
    @(posedge clk);
    #1;

    run(2'b00, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt);
    chk("div_m7_2", result, 32'hFFFF_FFFD);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt);
    chk("rem_m7_2", result, 32'hFFFF_FFFF);
    run(2'b10, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt);
    chk("rem_7_m2", result, 32'd1);
    run(2'b00, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt);
    chk("div_7_m2", result, 32'hFFFF_FFFD);

    run(2'b01, 32'd5, 32'd0, 0, lat, bcnt);
    chk("divu_by0", result, 32'hFFFF_FFFF);
    chk("by0_latency", lat, 1);
    chk("by0_busy_cycles", bcnt, 0);
    run(2'b10, 32'hFFFF_FFFB, 32'd0, 0, lat, bcnt);
    chk("rem_by0", result, 32'hFFFF_FFFB);
    run(2'b00, 32'hFFFF_FFFB, 32'd0, 0, lat, bcnt);
    chk("div_by0", result, 32'hFFFF_FFFF);

    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
    chk("div_overflow", result, 32'h8000_0000);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
    chk("rem_overflow", result, 32'd0);
    chk("rem_overflow_zero", {31'd0, zero}, 32'd1);

    run(2'b01, 32'hFFFF_FFFF, 32'h0000_0010, 0, lat, bcnt);
    chk("divu_large", result, 32'h0FFF_FFFF);
    run(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 0, lat, bcnt);
    chk("remu_large", result, 32'h0000_000F);

    // A start during CALC must be ignored entirely.
    run(2'b01, 32'd100, 32'd7, 5, lat, bcnt);
    chk("ignored_start_result", result, 32'd14);
    chk("ignored_start_latency", lat, 33);
    @(posedge clk);
    #1;
    chk("ignored_start_no_rerun", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_zero", {31'd0, zero}, 32'd1);
    $display("reset asserted mid-CALC: busy=%0b done=%0b result=%h", busy, done, result);
    #4;
    reset_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    chk("post_reset_quiet", dcnt, 0);

    run(2'b01, 32'd100, 32'd3, 0, lat, bcnt);
    chk("post_reset_divu", result, 32'd33);
    chk("post_reset_latency", lat, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
